// File: rtl/riscv_defines.sv
// Shared core definitions: fetch NOP encoding and instruction-memory state type.
package riscv_defines;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } instr_mem_state_t;

  // True when a byte offset lands inside a 2^aw-word array.
  function automatic logic off_in_range(input logic [31:0] off, input int unsigned aw);
    return (off >> (aw + 2)) == 32'h0;
  endfunction

endpackage

// File: rtl/instr_mem_sram_1rw.sv
// Behavioural single-port instruction array: synchronous read, byte-enabled synchronous write.
module instr_mem_sram_1rw #(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_BYTES  = 4
) (
  input  logic                           clk,
  input  logic                           req,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [NUM_BYTES-1:0][7:0]      wdata,
  input  logic [NUM_BYTES-1:0]           be,
  output logic [NUM_BYTES-1:0][7:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [NUM_BYTES-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (req && we) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (be[b]) mem[addr][b] <= wdata[b];
      end
    end
  end

  // Read register only moves on a read, so it holds across idle and write cycles.
  always_ff @(posedge clk) begin
    if (req && !we) rdata <= mem[addr];
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-bus responder: 1-cycle fetch, loader write port with fetch priority.
// Optional power-up NOP sweep compiled in with INSTR_MEM_CLEAR_EN.
module instr_mem_responder
  import riscv_defines::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_req_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  input  logic [3:0]  load_be_i,
  output logic        load_gnt_o,
  output logic        busy_o
);

  instr_mem_state_t        state;
  logic                    clr_we;
  logic [ADDR_WIDTH-1:0]   clr_addr;

`ifdef INSTR_MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   clr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_cnt_q <= '0;
    end else if (state == INIT) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state <= READY;
    end
  end

  assign clr_we   = (state == INIT);
  assign clr_addr = clr_cnt_q;
  assign busy_o   = (state == INIT);
`else
  assign state    = READY;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy_o   = 1'b0;
`endif

  logic [31:0] fetch_off, load_off;
  logic        ready, fetch_acc, fetch_ok, load_ok;

  assign ready      = (state == READY);
  assign fetch_off  = instr_addr_i - BASE_ADDR;
  assign load_off   = load_addr_i - BASE_ADDR;
  assign fetch_ok   = (instr_addr_i[1:0] == 2'b00) && off_in_range(fetch_off, ADDR_WIDTH);
  // Misaligned or out-of-range loads are still granted, just never reach the array.
  assign load_ok    = (load_addr_i[1:0] == 2'b00) && off_in_range(load_off, ADDR_WIDTH);
  assign fetch_acc  = ready && instr_req_i;
  assign load_gnt_o = load_req_i && !instr_req_i && ready;

  logic                  mem_req, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0][7:0]       mem_wdata, mem_rdata;
  logic [3:0]            mem_be;

  assign mem_req   = clr_we || (fetch_acc && fetch_ok) || (load_gnt_o && load_ok);
  assign mem_we    = clr_we || (load_gnt_o && load_ok);
  assign mem_addr  = clr_we      ? clr_addr :
                     instr_req_i ? fetch_off[ADDR_WIDTH+1:2] : load_off[ADDR_WIDTH+1:2];
  assign mem_wdata = clr_we ? INSTR_NOP : load_wdata_i;
  assign mem_be    = clr_we ? 4'hF : load_be_i;

  instr_mem_sram_1rw #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BYTES  (4)
  ) u_sram (
    .clk   (clk),
    .req   (mem_req),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .be    (mem_be),
    .rdata (mem_rdata)
  );

  // Response select flags; rdata is a registered-source mux so it resets to 0
  // and holds NOP after an error response until the next accepted fetch.
  logic rvalid_q, err_q, nop_q, zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      nop_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      rvalid_q <= fetch_acc;
      err_q    <= fetch_acc && !fetch_ok;
      if (fetch_acc) begin
        nop_q  <= !fetch_ok;
        zero_q <= 1'b0;
      end
    end
  end

  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = err_q;
  assign instr_rdata_o  = zero_q ? 32'h0 : (nop_q ? INSTR_NOP : mem_rdata);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench for instr_mem_responder (ADDR_WIDTH=4, nonzero base); follows INSTR_MEM_CLEAR_EN.
module tb_instr_mem_responder;

  localparam int          AW   = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef INSTR_MEM_CLEAR_EN
  localparam int CLR_CYC = 16;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req_i = 1'b0;
  logic [31:0] instr_addr_i = '0;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        load_req_i = 1'b0;
  logic [31:0] load_addr_i = '0;
  logic [31:0] load_wdata_i = '0;
  logic [3:0]  load_be_i = '0;
  logic        load_gnt_o;
  logic        busy_o;

  instr_mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .load_req_i     (load_req_i),
    .load_addr_i    (load_addr_i),
    .load_wdata_i   (load_wdata_i),
    .load_be_i      (load_be_i),
    .load_gnt_o     (load_gnt_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [31:0] data; logic err; } rsp_t;
  rsp_t        sb[$];
  logic [31:0] ref_mem [16];
  bit          known   [16];
  bit          tb_ready = 1'b0;
  bit          req_seen = 1'b0;
  logic [31:0] last_rdata = '0;

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] == 2'b00) && ((off >> (AW + 2)) == 32'h0);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[AW+1:2]);
  endfunction

  // Monitor: a fetch seen while ready must come back on the next cycle.
  always @(posedge clk) req_seen = rst_n && instr_req_i && tb_ready;

  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      req_seen   = 1'b0;
      last_rdata = '0;
    end else begin
      chk("rvalid", {31'b0, instr_rvalid_o}, {31'b0, req_seen});
      if (instr_rvalid_o) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
        else begin
          e = sb.pop_front();
          chk("rdata", instr_rdata_o, e.data);
          chk("err", {31'b0, instr_err_o}, {31'b0, e.err});
        end
        last_rdata = instr_rdata_o;
      end else begin
        chk("rdata_hold", instr_rdata_o, last_rdata);
      end
    end
  end

  task automatic cyc(input bit req, input logic [31:0] addr, input bit lreq,
                     input logic [31:0] laddr, input logic [31:0] wd, input logic [3:0] be);
    bit exp_gnt;
    int i;
    instr_req_i  = req;
    instr_addr_i = addr;
    load_req_i   = lreq;
    load_addr_i  = laddr;
    load_wdata_i = wd;
    load_be_i    = be;
    exp_gnt = lreq && !req && tb_ready;
    if (req && tb_ready) begin
      if (addr_ok(addr)) sb.push_back('{data: ref_mem[word_idx(addr)], err: 1'b0});
      else               sb.push_back('{data: NOP, err: 1'b1});
    end
    #1 chk("load_gnt", {31'b0, load_gnt_o}, {31'b0, exp_gnt});
    if (exp_gnt && addr_ok(laddr)) begin
      i = word_idx(laddr);
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[i][8*b +: 8] = wd[8*b +: 8];
      known[i] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] a);
    cyc(1'b1, a, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cyc(1'b0, '0, 1'b1, a, d, be);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rvalid"}, {31'b0, instr_rvalid_o}, 32'd0);
    chk({tag, "_rdata"}, instr_rdata_o, 32'd0);
    chk({tag, "_err"}, {31'b0, instr_err_o}, 32'd0);
  endtask

  // Counts busy cycles after reset release; fetches issued meanwhile must be ignored.
  task automatic wait_ready(input int exp_cyc);
    int cnt = 0;
`ifdef INSTR_MEM_CLEAR_EN
    instr_req_i  = 1'b1;
    instr_addr_i = BASE + 32'h8;
`endif
    forever begin
      @(negedge clk);
      if (!busy_o || cnt > 200) break;
      cnt++;
    end
    instr_req_i = 1'b0;
    tb_ready    = 1'b1;
    chk("busy_cycles", cnt, exp_cyc);
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = NOP;
      known[i]   = (CLR_CYC != 0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb.delete();
    tb_ready    = 1'b0;
    instr_req_i = 1'b0;
    load_req_i  = 1'b0;
    #1 chk_reset_outs("rst");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy_o}, (CLR_CYC != 0) ? 32'd1 : 32'd0);
    chk("rst_gnt", {31'b0, load_gnt_o}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    apply_reset();
    wait_ready(CLR_CYC);
    if (CLR_CYC != 0) fetch(BASE + 32'h8);

    load(BASE + 32'h30, 32'hDEAD_BEEF, 4'hF);
    fetch(BASE + 32'h30);

    load(BASE + 32'h10, 32'h1111_1111, 4'hF);
    load(BASE + 32'h10, 32'h00AB_0000, 4'b0100);
    fetch(BASE + 32'h10);
    chk("byte_merge", ref_mem[4], 32'h11AB_1111);

    repeat (3) cyc(1'b1, BASE + 32'h30, 1'b1, BASE + 32'h14, 32'h55AA_1234, 4'hF);
    cyc(1'b0, '0, 1'b1, BASE + 32'h14, 32'h55AA_1234, 4'hF);
    fetch(BASE + 32'h14);
    fetch(BASE + 32'h10);
    fetch(BASE + 32'h30);

    fetch(BASE + 32'h2);
    fetch(BASE + 32'h40);
    fetch(BASE - 32'h4);
    idle();

    load(BASE + 32'h0, 32'h1234_5678, 4'hF);
    load(BASE + 32'h40, 32'hCAFE_F00D, 4'hF);
    fetch(BASE + 32'h0);
    idle();

    // Reset while a response is on the bus.
    instr_req_i  = 1'b1;
    instr_addr_i = BASE + 32'h30;
    @(posedge clk); #1;
    chk("pre_rst_rvalid", {31'b0, instr_rvalid_o}, 32'd1);
    chk("pre_rst_rdata", instr_rdata_o, 32'hDEAD_BEEF);
    apply_reset();
    wait_ready(CLR_CYC);

`ifdef INSTR_MEM_CLEAR_EN
    // Reset mid-sweep at word 5: outputs clear and the sweep restarts from 0.
    fetch(BASE + 32'h30);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tb_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    sb.delete();
    rst_n = 1'b0;
    #1 chk_reset_outs("midclr");
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(CLR_CYC);
    fetch(BASE + 32'h30);
`else
    load(BASE + 32'h3C, 32'hA5A5_0F0F, 4'hF);
    fetch(BASE + 32'h3C);
`endif
    idle();
    idle();
    if (sb.size() != 0) chk("sb_leftover", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
